// File: rtl/spi_regfile_pkg.sv
// Shared types and frame constants for the SPI register file.
package spi_regfile_pkg;

    typedef enum logic [1:0] {StIdle, StHdr, StData, StOver} state_e;

    localparam int unsigned HDR_W  = 8;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned RW_BIT = 7;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser with registered rise/fall pulses for one SPI pin.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/spi_regfile.sv
// SPI mode-0 peripheral with a write/read-back register bank, fully sampled in the clk domain.
module spi_regfile
    import spi_regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 5,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       wr_strobe,
    output logic [6:0]                 wr_addr,
    output logic                       frame_err
);

    localparam int unsigned FRAME_W = HDR_W + DATA_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);

    logic sclk_s, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;
    logic ncs_s, ncs_rise, ncs_fall;
    logic unused_sync;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk), .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(copi), .level(copi_s), .rise(copi_rise), .fall(copi_fall)
    );
    // ncs idles high so reset release never looks like a select.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(ncs), .level(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
    );

    assign unused_sync = sclk_s ^ copi_rise ^ copi_fall;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HDR_W-1:0]    hdr_q, hdr_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic                loaded_q, loaded_d;
    logic [DATA_W-1:0]   reg_q [NUM_REGS];
    logic                wr_strobe_q, frame_err_q;
    logic [6:0]          wr_addr_q;
    logic                commit, err;
    logic [ADDR_W-1:0]   addr;
    logic                addr_ok;
    logic [DATA_W-1:0]   rd_data;

    assign addr    = hdr_q[ADDR_W-1:0];
    assign addr_ok = 32'(addr) < NUM_REGS;

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr == ADDR_W'(k)) rd_data = reg_q[k];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hdr_d    = hdr_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        loaded_d = loaded_q;
        commit   = 1'b0;
        err      = 1'b0;
        // Deselect has priority over any sclk edge detected in the same cycle.
        if (ncs_rise) begin
            state_d  = StIdle;
            tx_d     = '0;
            loaded_d = 1'b0;
            if (state_q != StIdle) begin
                if (cnt_q != CNT_W'(FRAME_W) || !addr_ok) err = 1'b1;
                else if (hdr_q[RW_BIT])                   commit = 1'b1;
            end
        end else if (ncs_fall) begin
            state_d  = StHdr;
            cnt_d    = '0;
            hdr_d    = '0;
            rx_d     = '0;
            tx_d     = '0;
            loaded_d = 1'b0;
        end else begin
            if (sclk_rise && state_q != StIdle) begin
                rx_d = DATA_W'({rx_q, copi_s});
                if (state_q != StOver) cnt_d = cnt_q + CNT_W'(1);
                case (state_q)
                    StHdr: begin
                        hdr_d = {hdr_q[HDR_W-2:0], copi_s};
                        if (cnt_q == CNT_W'(HDR_W - 1)) state_d = StData;
                    end
                    StData: begin
                        if (cnt_q == CNT_W'(FRAME_W)) state_d = StOver;
                    end
                    default: ;
                endcase
            end
            if (sclk_fall && state_q == StData) begin
                if (!loaded_q) begin
                    tx_d     = rd_data;
                    loaded_d = 1'b1;
                end else begin
                    tx_d = DATA_W'({tx_q, 1'b0});
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hdr_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            loaded_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            wr_addr_q   <= '0;
            for (int k = 0; k < NUM_REGS; k++) reg_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            loaded_q    <= loaded_d;
            wr_strobe_q <= commit;
            frame_err_q <= err;
            if (commit) wr_addr_q <= addr;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (commit && addr == ADDR_W'(k)) reg_q[k] <= rx_q;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
        assign regs[k*DATA_W +: DATA_W] = reg_q[k];
    end

    assign cipo_oe   = ~ncs_s;
    assign cipo      = ~ncs_s & tx_q[DATA_W-1];
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/spi_regfile.md
# spi_regfile

Parametrised SPI (mode 0) peripheral with a register bank of `NUM_REGS` registers, each `DATA_W` bits. It supports both register writes and read-back over CIPO. Sits between the external SPI pins and the PWM/control logic, which consumes the flattened register outputs. It samples all SPI pins in the `clk` domain, so there is no `sclk`-clocked logic.

## Interface
Reset `rst_n`: asynchronous, active-low. Clock: `clk`.

Parameters:
- `NUM_REGS`, 5: number of registers. Valid addresses are 0..NUM_REGS-1. Range 1..128.
- `DATA_W`, 8: register width and data-phase length in bits. Range 1..32.
- `SYNC_STAGES`, 2: synchroniser depth on `sclk`, `copi`, `ncs`. Minimum 2.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  async active-low reset
- `sclk`  in  1  SPI clock from controller
- `copi`  in  1  controller-out data
- `ncs`  in  1  chip select, active low
- `cipo`  out  1  peripheral-out data. 0 when not driving.
- `cipo_oe`  out  1  CIPO output enable for the pad
- `regs`  out  NUM_REGS*DATA_W  register contents. Register k is at `[k*DATA_W +: DATA_W]`.
- `wr_strobe`  out  1  one-cycle pulse when a write commits
- `wr_addr`  out  7  address of the last committed write
- `frame_err`  out  1  one-cycle pulse when a frame is rejected

## Operation
- **Frame format:** 8 header bits, then DATA_W data bits, all MSB-first.
  - Header bit 7 is R/W: 1 = write, 0 = read.
  - Header bits 6:0 are the address.
- **Mode 0:**
  - `copi` is sampled on synchronised `sclk` rising edges.
  - `cipo` changes on synchronised `sclk` falling edges.
- **States:**
  - IDLE: `ncs` high.
  - HDR: collecting 8 header bits.
  - DATA: collecting or transmitting DATA_W bits.
  - OVER: more than 8+DATA_W rising edges seen.
- **Transitions:**
  - IDLE→HDR on synchronised `ncs` fall. The bit counter and shift register clear.
  - HDR→DATA on the 8th rising edge.
  - DATA→OVER on rising edge number 8+DATA_W+1.
  - Any state →IDLE on synchronised `ncs` rise.
- **Write commit:** occurs on the `ncs` rise when all of the following hold:
  - R/W = 1,
  - exactly 8+DATA_W rising edges were counted,
  - address < NUM_REGS.
  - On commit, the register is updated, `wr_strobe` pulses and `wr_addr` is updated.
- **Write rejection:** a write frame that fails any commit condition pulses `frame_err`. No register changes.
- **Reads:**
  - On the first falling edge after the 8th rising edge, the shifter loads `reg[addr]` and `cipo` presents the MSB.
  - Each later falling edge shifts left.
  - Address ≥ NUM_REGS reads all zeros and pulses `frame_err` at `ncs` rise.
  - A read with the wrong bit count pulses `frame_err`. Reads never modify registers.
- **`cipo_oe`:** equals NOT synchronised `ncs`. `cipo` is 0 whenever `cipo_oe` is 0.
- **Simultaneous events:** if the `ncs` rise and an `sclk` edge are detected in the same cycle, the `ncs` rise wins and the `sclk` edge is ignored.
- **Restart:** an `ncs` fall while already in HDR or DATA (re-select without an observed rise) restarts the frame. No commit and no error.
- **Reset:**
  - All registers, shifters, counters, the state and every output go to 0.
  - State goes to IDLE. This holds mid-frame too, and the partial frame is discarded.
  - The synchroniser reset value for `ncs` is 1, so reset release does not fake a frame start.

## Timing
- Input latency is SYNC_STAGES cycles to the synchronised value, plus 1 cycle to edge detect.
- Requirement: `sclk` high and low phases each ≥ SYNC_STAGES+2 `clk` cycles.
- Commit latency: `regs`, `wr_strobe`, `wr_addr` and `frame_err` update on the clk edge after the `ncs` rise is detected. That is SYNC_STAGES+2 cycles after the pin rises.
- `wr_strobe` and `frame_err` are mutually exclusive and last exactly 1 cycle.
- `cipo` valid latency is SYNC_STAGES+2 cycles after the `sclk` pin falls. The controller samples on the next rising edge.
- Back-to-back frames need `ncs` high for ≥ SYNC_STAGES+2 cycles.

## Structure
- Package `spi_regfile_pkg` holds:
  - the state enum (IDLE, HDR, DATA, OVER),
  - `HDR_W = 8`, `ADDR_W = 7`,
  - `RW_BIT = 7`.
- Sub-module `spi_sync_edge`:
  - parameters: SYNC_STAGES and the reset value;
  - outputs: the synchronised level, a rise pulse and a fall pulse;
  - instantiated once each for `sclk`, `copi` and `ncs`.
- Top level contains the FSM, the bit counter (width clog2(8+DATA_W+2)), the RX/TX shifters and the register array.

## Test plan
- Write 0x81,0xA5 (addr 1, data 0xA5) with defaults → `regs[15:8]`=0xA5, `wr_strobe` for 1 cycle, `wr_addr`=1, other registers 0.
- Write addr 4 data 0x3C, then read addr 4 (header 0x04) → `cipo` bits 0,0,1,1,1,1,0,0 sampled on the data-phase rising edges. `cipo_oe` high only while selected.
- Write addr 5 (header 0x85) → `frame_err` pulse, `regs` unchanged, no `wr_strobe`.
- Write frame with 15 bits, then another with 17 bits → `frame_err` twice, no commit.
- Deassert `rst_n` mid-data-phase of a write → every output 0 immediately. The next full write commits normally.
- NUM_REGS=16, DATA_W=16: write addr 15 data 0xBEEF, then read it back → `regs[255:240]`=0xBEEF and the read returns 0xBEEF MSB-first.
